// File: rtl/debounce_multi_pkg.sv
// Shared FSM encoding and width helpers for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_QUALIFY,
        ST_LOCKED,
        ST_RELEASING
    } state_t;

    localparam int unsigned DEF_NUM_CH          = 5;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1048576;
    localparam int unsigned DEF_RELEASE_CYCLES  = 1024;

    // The counter is shared by qualify and release, so it must hold the larger limit.
    function automatic int unsigned cnt_width(input int unsigned deb, input int unsigned rel);
        int unsigned m;
        m = (deb > rel) ? deb : rel;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic int unsigned onehot_index(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_multi_sync.sv
// Per-bit two-flop synchroniser for asynchronous channel levels.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel press debouncer: one shared qualify/release counter, one press per press-release cycle.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned RELEASE_CYCLES  = DEF_RELEASE_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              raw_in,
    output logic [NUM_CH-1:0]              press_pulse,
    output logic [idx_width(NUM_CH)-1:0]   press_idx,
    output logic                           press_valid,
    output logic                           multi_err,
    output logic                           armed
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, RELEASE_CYCLES);
    localparam int unsigned IDX_W = idx_width(NUM_CH);
    localparam logic [CNT_W-1:0] QUAL_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] s_prev;
    logic [CNT_W-1:0]  cnt;
    state_t            state;

    logic              s_zero;
    logic              s_single;
    logic [CNT_W-1:0]  qual_next;

    sync_2ff #(.WIDTH(NUM_CH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (s)
    );

    always_comb begin
        s_zero   = (s == '0);
        s_single = ((s & (s - NUM_CH'(1))) == '0);
        qual_next = '0;
        if (!s_zero && (s == s_prev)) begin
            qual_next = (cnt == QUAL_MAX) ? QUAL_MAX : cnt + CNT_W'(1);
        end
    end

    // Firing is keyed on the counter's next value so the pulse lands on the same edge it saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ARMED;
            cnt         <= '0;
            s_prev      <= '0;
            press_pulse <= '0;
            press_idx   <= '0;
            press_valid <= 1'b0;
            multi_err   <= 1'b0;
            armed       <= 1'b1;
        end else begin
            s_prev      <= s;
            press_pulse <= '0;
            press_idx   <= '0;
            press_valid <= 1'b0;
            multi_err   <= 1'b0;
            case (state)
                ST_ARMED: begin
                    cnt   <= qual_next;
                    armed <= 1'b1;
                    if (!s_zero) state <= ST_QUALIFY;
                end
                ST_QUALIFY: begin
                    armed <= 1'b1;
                    if (s_zero) begin
                        state <= ST_ARMED;
                        cnt   <= '0;
                    end else if (qual_next == QUAL_MAX) begin
                        state <= ST_LOCKED;
                        cnt   <= '0;
                        armed <= 1'b0;
                        if (s_single) begin
                            press_pulse <= s;
                            press_idx   <= IDX_W'(onehot_index(32'(s)));
                            press_valid <= 1'b1;
                        end else begin
                            multi_err <= 1'b1;
                        end
                    end else begin
                        cnt <= qual_next;
                    end
                end
                ST_LOCKED: begin
                    cnt   <= '0;
                    armed <= 1'b0;
                    if (s_zero) begin
                        if (RELEASE_CYCLES <= 1) begin
                            state <= ST_ARMED;
                            armed <= 1'b1;
                        end else begin
                            state <= ST_RELEASING;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                ST_RELEASING: begin
                    armed <= 1'b0;
                    if (!s_zero) begin
                        state <= ST_LOCKED;
                        cnt   <= '0;
                    end else if (cnt == REL_LAST) begin
                        state <= ST_ARMED;
                        cnt   <= '0;
                        armed <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_ARMED;
                    cnt   <= '0;
                    armed <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random bursts against a window-based reference model.
module tb_debounce_multi;

    localparam int NCH = 5;
    localparam int D   = 8;
    localparam int R   = 4;
    localparam int IW  = 3;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] raw_in;
    logic [NCH-1:0] press_pulse;
    logic [IW-1:0]  press_idx;
    logic           press_valid;
    logic           multi_err;
    logic           armed;

    int nvec;
    int nerr;

    debounce_multi #(
        .NUM_CH          (NCH),
        .DEBOUNCE_CYCLES (D),
        .RELEASE_CYCLES  (R)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_in      (raw_in),
        .press_pulse (press_pulse),
        .press_idx   (press_idx),
        .press_valid (press_valid),
        .multi_err   (multi_err),
        .armed       (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a press fires when the last D+1 synchronised samples are one equal non-zero
    // vector while armed; re-arming needs R consecutive all-zero synchronised samples.
    logic [NCH-1:0] hist [0:D+1];
    logic           m_armed;
    int             zr;
    logic [NCH-1:0] exp_pulse;
    logic [IW-1:0]  exp_idx;
    logic           exp_valid;
    logic           exp_err;
    logic           exp_armed;

    always @(posedge clk or negedge rst_n) begin : model
        logic [NCH-1:0] cur;
        logic           stable;
        logic           fire;
        logic           nxt_armed;
        int             ones;
        int             zr_n;
        int             idx;
        if (!rst_n) begin
            for (int i = 0; i <= D + 1; i++) hist[i] <= '0;
            m_armed   <= 1'b1;
            zr        <= 0;
            exp_pulse <= '0;
            exp_idx   <= '0;
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
            exp_armed <= 1'b1;
        end else begin
            cur    = hist[1];
            stable = (cur != '0);
            for (int i = 2; i <= D + 1; i++) if (hist[i] != cur) stable = 1'b0;
            fire = m_armed && stable;
            ones = $countones(cur);
            idx  = 0;
            for (int i = 0; i < NCH; i++) if (cur == (NCH'(1) << i)) idx = i;
            nxt_armed = m_armed;
            zr_n      = 0;
            if (fire) begin
                nxt_armed = 1'b0;
            end else if (!m_armed) begin
                zr_n = (cur == '0) ? zr + 1 : 0;
                if (zr_n == R) begin
                    nxt_armed = 1'b1;
                    zr_n      = 0;
                end
            end
            exp_valid <= fire && (ones == 1);
            exp_pulse <= (fire && ones == 1) ? cur : '0;
            exp_idx   <= (fire && ones == 1) ? IW'(idx) : '0;
            exp_err   <= fire && (ones > 1);
            exp_armed <= nxt_armed;
            m_armed   <= nxt_armed;
            zr        <= zr_n;
            for (int i = D + 1; i >= 1; i--) hist[i] <= hist[i-1];
            hist[0] <= raw_in;
        end
    end

    task automatic idle(input int n);
        raw_in = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        raw_in = 5'b00001;
        repeat (3) @(negedge clk);
        nvec++;
        if ({press_pulse, press_idx, press_valid, multi_err, armed} !== {5'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL reset got=%b required=%b", {press_pulse, press_idx, press_valid, multi_err, armed},
                     {5'b0, 3'd0, 1'b0, 1'b0, 1'b1});
        end
        raw_in = '0;
        rst_n  = 1'b1;
    endtask

    task automatic test_single_press();
        int npulse = 0;
        int at     = -1;
        raw_in = 5'b00100;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            nvec++;
            if ({press_pulse, press_idx, press_valid, multi_err, armed} !==
                {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed}) begin
                nerr++;
                $display("FAIL single c=%0d got=%b required=%b", c,
                         {press_pulse, press_idx, press_valid, multi_err, armed},
                         {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed});
            end
            if (press_valid) begin
                npulse++;
                at = c;
                if (press_pulse !== 5'b00100 || press_idx !== 3'd2) begin
                    nerr++;
                    $display("FAIL single_payload pulse=%b idx=%0d required 00100/2", press_pulse, press_idx);
                end
            end
        end
        nvec++;
        if (npulse != 1 || at != 10) begin
            nerr++;
            $display("FAIL single_timing pulses=%0d at=%0d required 1 at 10", npulse, at);
        end
    endtask

    task automatic test_bounce();
        int bad = 0;
        for (int c = 0; c < 40; c++) begin
            raw_in = (c % 5 == 4) ? 5'b00000 : 5'b00100;
            @(negedge clk);
            nvec++;
            if ({press_pulse, press_idx, press_valid, multi_err, armed} !==
                {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed}) begin
                nerr++;
                $display("FAIL bounce c=%0d got=%b required=%b", c,
                         {press_pulse, press_idx, press_valid, multi_err, armed},
                         {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed});
            end
            if (press_valid || multi_err) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL bounce_events events=%0d required 0", bad);
        end
    endtask

    task automatic test_multi();
        int nerrp = 0;
        int npulse = 0;
        raw_in = 5'b10010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            nvec++;
            if ({press_pulse, press_idx, press_valid, multi_err, armed} !==
                {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed}) begin
                nerr++;
                $display("FAIL multi c=%0d got=%b required=%b", c,
                         {press_pulse, press_idx, press_valid, multi_err, armed},
                         {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed});
            end
            if (multi_err) nerrp++;
            if (press_pulse != '0) npulse++;
        end
        nvec++;
        if (nerrp != 1 || npulse != 0) begin
            nerr++;
            $display("FAIL multi_count errs=%0d pulses=%0d required 1/0", nerrp, npulse);
        end
    endtask

    task automatic test_rearm();
        int npulse = 0;
        for (int c = 0; c < 50; c++) begin
            raw_in = ((c >= 14 && c < 16) || (c >= 30 && c < 36)) ? 5'b00000 : 5'b00001;
            @(negedge clk);
            nvec++;
            if ({press_pulse, press_idx, press_valid, multi_err, armed} !==
                {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed}) begin
                nerr++;
                $display("FAIL rearm c=%0d got=%b required=%b", c,
                         {press_pulse, press_idx, press_valid, multi_err, armed},
                         {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed});
            end
            if (press_valid) npulse++;
        end
        nvec++;
        if (npulse != 2) begin
            nerr++;
            $display("FAIL rearm_count pulses=%0d required 2", npulse);
        end
    endtask

    task automatic test_reset_abort();
        int npulse = 0;
        int at     = -1;
        raw_in = 5'b00010;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            nvec++;
            if ({press_pulse, press_idx, press_valid, multi_err, armed} !==
                {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed}) begin
                nerr++;
                $display("FAIL reset_abort c=%0d got=%b required=%b", c,
                         {press_pulse, press_idx, press_valid, multi_err, armed},
                         {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed});
            end
            if (press_valid) begin
                npulse++;
                at = c;
            end
            if (c == 4) rst_n = 1'b0;
            if (c == 6) rst_n = 1'b1;
        end
        nvec++;
        if (npulse != 1 || at != 17) begin
            nerr++;
            $display("FAIL reset_abort_timing pulses=%0d at=%0d required 1 at 17", npulse, at);
        end
    endtask

    task automatic test_change_restart();
        int at = -1;
        int n  = 0;
        raw_in = 5'b01000;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            nvec++;
            if ({press_pulse, press_idx, press_valid, multi_err, armed} !==
                {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed}) begin
                nerr++;
                $display("FAIL change c=%0d got=%b required=%b", c,
                         {press_pulse, press_idx, press_valid, multi_err, armed},
                         {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed});
            end
            if (multi_err || press_valid) begin
                n++;
                at = c;
            end
            if (c == 3) raw_in = 5'b11000;
        end
        nvec++;
        if (n != 1 || at != 14 || multi_err !== 1'b0) begin
            nerr++;
            $display("FAIL change_timing events=%0d at=%0d required 1 at 14", n, at);
        end
    endtask

    task automatic test_random();
        int left = 0;
        for (int c = 0; c < 900; c++) begin
            if (left == 0) begin
                case ($urandom_range(3, 0))
                    0:       raw_in = '0;
                    1:       raw_in = NCH'($urandom_range(31, 0));
                    default: raw_in = NCH'(1) << $urandom_range(NCH - 1, 0);
                endcase
                left = $urandom_range(14, 1);
            end
            left--;
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(99, 0) == 0) rst_n = 1'b0;
            @(negedge clk);
            nvec++;
            if ({press_pulse, press_idx, press_valid, multi_err, armed} !==
                {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed}) begin
                nerr++;
                $display("FAIL random c=%0d raw=%b got=%b required=%b", c, raw_in,
                         {press_pulse, press_idx, press_valid, multi_err, armed},
                         {exp_pulse, exp_idx, exp_valid, exp_err, exp_armed});
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        nvec   = 0;
        nerr   = 0;
        rst_n  = 1'b0;
        raw_in = '0;
        test_reset();
        idle(12);
        test_single_press();
        idle(12);
        test_bounce();
        idle(12);
        test_multi();
        idle(12);
        test_rearm();
        idle(12);
        test_reset_abort();
        idle(12);
        test_change_restart();
        idle(12);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter NUM_CH, default 5, number of raw button/coin channels (2..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1048576, stable cycles required before a press qualifies (>=2).
REQ-003 Parameter RELEASE_CYCLES, default 1024, consecutive all-low cycles required to re-arm (>=1).
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 raw_in  input  NUM_CH  asynchronous raw channel levels, active-high.
REQ-007 press_pulse  output  NUM_CH  one-hot, one-cycle pulse on the qualified channel.
REQ-008 press_idx  output  clog2(NUM_CH)  binary index of the qualified channel, valid with press_valid.
REQ-009 press_valid  output  1  one-cycle pulse, high exactly when press_pulse != 0.
REQ-010 multi_err  output  1  one-cycle pulse when a stable vector with >1 bit set qualifies.
REQ-011 armed  output  1  level, high while the block can accept a new press.

Function
REQ-012 raw_in SHALL pass through a 2-flop synchroniser per bit, giving sync vector s.
REQ-013 Qualify counter SHALL be shared across channels, width clog2(DEBOUNCE_CYCLES+1).
REQ-014 Counter SHALL clear when s == 0 or s differs from its previous-cycle value; otherwise it increments, saturating at DEBOUNCE_CYCLES.
REQ-015 FSM states: ARMED (s==0, waiting), QUALIFY (counting), LOCKED (fired, waiting release), RELEASING (counting all-low).
REQ-016 ARMED->QUALIFY when s != 0; QUALIFY->ARMED when s == 0.
REQ-017 QUALIFY->LOCKED on the cycle the counter reaches DEBOUNCE_CYCLES.
REQ-018 On that transition, exactly one bit set in s: press_pulse=s, press_idx=index, press_valid=1 for one registered cycle.
REQ-019 On that transition, >1 bit set in s: multi_err=1 for one cycle; press_pulse stays 0.
REQ-020 Latency: if edge k is the first edge at which raw_in holds a stable new value, the pulse SHALL be high in the cycle after edge k+DEBOUNCE_CYCLES+2.
REQ-021 LOCKED->RELEASING when s == 0; RELEASING->LOCKED if any s bit rises before RELEASE_CYCLES elapse.
REQ-022 RELEASING->ARMED after RELEASE_CYCLES consecutive s == 0 cycles; the release count reuses the shared counter.
REQ-023 A held input SHALL never produce a second pulse; at most one pulse or error per press-release cycle.
REQ-024 A vector change during QUALIFY (e.g. second channel joins) SHALL restart qualification from 0.
REQ-025 armed SHALL be high only in ARMED and QUALIFY.
REQ-026 press_idx SHALL read 0 when press_valid is low.

Reset
REQ-027 rst_n low SHALL asynchronously clear synchroniser flops, counter, and all outputs except armed; FSM enters ARMED, armed=1.
REQ-028 Reset asserted mid-QUALIFY or LOCKED SHALL abort without emitting a pulse; after release, a still-held input SHALL requalify from zero.

Structure
REQ-029 Package debounce_pkg SHALL hold the FSM state encoding and the clog2-derived width constants.
REQ-030 One sub-module sync_2ff (parametrised width, async active-low reset) SHALL implement REQ-012.

Verification (NUM_CH=5, DEBOUNCE_CYCLES=8, RELEASE_CYCLES=4)
REQ-031 raw_in=5'b00100 held from edge 0 -> press_pulse=5'b00100, press_idx=2, press_valid=1 for one cycle after edge 10; nothing after while held.
REQ-032 raw_in=5'b00100 toggled low every 5 cycles for 40 cycles -> no press_valid, no multi_err.
REQ-033 raw_in=5'b10010 held 20 cycles -> multi_err one cycle; press_pulse stays 0.
REQ-034 Press ch0, release 2 cycles, press ch0 again -> only one pulse; release 6 cycles then press -> second pulse.
REQ-035 Press ch1, rst_n low at cycle 5 for 2 cycles, input held -> no pulse before reset; one pulse 11 cycles after reset release.
REQ-036 ch3 held 4 cycles then ch4 added -> counter restarts; multi_err 11 cycles after the change.
